// File: rtl/countones_pkg.sv
// Shared types and mask helpers for the fixed-popcount pattern generator.
package countones_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MAX_WIDTH = 32;

    // k low bits set; k is clamped to width so callers never overflow the word.
    function automatic logic [MAX_WIDTH-1:0] ones_mask(input int unsigned k,
                                                       input int unsigned width);
        logic [MAX_WIDTH:0] m;
        int unsigned        kk;
        kk = (k > width) ? width : k;
        m  = ({{MAX_WIDTH{1'b0}}, 1'b1} << kk) - {{MAX_WIDTH{1'b0}}, 1'b1};
        return m[MAX_WIDTH-1:0];
    endfunction

    function automatic logic [MAX_WIDTH-1:0] top_mask(input int unsigned k,
                                                      input int unsigned width);
        int unsigned kk;
        kk = (k > width) ? width : k;
        return ones_mask(kk, width) << (width - kk);
    endfunction

endpackage

// File: rtl/countones_ctz.sv
// Combinational trailing-zero count; an all-zero input reports width_p.
module countones_ctz #(
    parameter int unsigned width_p = 8
) (
    input  logic [width_p-1:0]       data_i,
    output logic [$clog2(width_p):0] count_o
);

    localparam int unsigned CW = $clog2(width_p) + 1;

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        count_o = CW'(width_p);
        for (int unsigned i = width_p; i > 0; i--) begin
            if (data_i[i-1]) begin
                count_o = CW'(i - 1);
            end
        end
    end

endmodule

// File: rtl/countones_gen.sv
// Streams every width_p-bit word with popcount k in ascending order,
// one word per accepted consumer handshake.
module countones_gen
    import countones_pkg::*;
#(
    parameter int unsigned width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [$clog2(width_p):0] count_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [width_p-1:0]       binary_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     err_o
);

    localparam int unsigned     CW   = $clog2(width_p) + 1;
    localparam logic [CW-1:0]   KMAX = CW'(width_p);

    state_e               state_q;
    logic [width_p-1:0]   pat_q;
    logic [width_p-1:0]   pat_d;
    logic [CW-1:0]        k_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 err_q;

    logic [MAX_WIDTH-1:0] first_w;
    logic [MAX_WIDTH-1:0] new_top_w;
    logic [MAX_WIDTH-1:0] cur_top_w;
    logic [width_p-1:0]   first_pat;
    logic [width_p-1:0]   new_top;
    logic [width_p-1:0]   cur_top;

    logic [width_p:0]     x_ext;
    logic [width_p:0]     c_ext;
    logic [width_p:0]     r_ext;
    logic [width_p:0]     succ_ext;
    logic [CW-1:0]        tz;

    logic                 accept;
    logic                 handshake;

    countones_ctz #(
        .width_p (width_p)
    ) u_ctz (
        .data_i  (pat_q),
        .count_o (tz)
    );

    always_comb begin
        first_w   = ones_mask(32'(count_i), width_p);
        new_top_w = top_mask(32'(count_i), width_p);
        cur_top_w = top_mask(32'(k_q), width_p);
        first_pat = first_w[width_p-1:0];
        new_top   = new_top_w[width_p-1:0];
        cur_top   = cur_top_w[width_p-1:0];
    end

    // Successor is formed one bit wider so the carry out of x + c survives the shift.
    always_comb begin
        x_ext    = {1'b0, pat_q};
        c_ext    = x_ext & (-x_ext);
        r_ext    = x_ext + c_ext;
        succ_ext = r_ext | (((r_ext ^ x_ext) >> 2) >> tz);
        pat_d    = succ_ext[width_p-1:0];
    end

    assign accept    = (state_q == IDLE) && valid_i && (count_i <= KMAX);
    assign handshake = valid_q && ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            pat_q   <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= RUN;
                        k_q     <= count_i;
                        pat_q   <= first_pat;
                        valid_q <= 1'b1;
                        last_q  <= (first_pat == new_top);
                    end else if (valid_i) begin
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            pat_q  <= pat_d;
                            last_q <= (pat_d == cur_top);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign binary_o = pat_q;
    assign last_o   = last_q;
    assign err_o    = err_q;

    a_stall_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (valid_q && !ready_i) |=> (valid_q && $stable(pat_q) && $stable(last_q)));

    a_popcount: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        valid_q |-> ($countones(pat_q) == int'(k_q)));

endmodule
